// File: rtl/countdown_timer_arbiter_pkg.sv
// Shared constants and helpers for countdown_timer_arbiter.
package countdown_timer_arbiter_pkg;
   localparam int NREQ          = 2;
   localparam int DEFAULT_WIDTH = 4;

   typedef enum logic {ST_IDLE = 1'b0, ST_COUNT = 1'b1} state_t;

   function automatic logic [NREQ-1:0] onehot(input logic idx);
      logic [NREQ-1:0] r;
      r      = '0;
      r[idx] = 1'b1;
      return r;
   endfunction
endpackage

// File: rtl/countdown_timer_arbiter_if.sv
// Requester-facing bus of countdown_timer_arbiter; Pause exists only with
// COUNTDOWN_TIMER_ARBITER_PAUSE_EN defined.
interface countdown_timer_arbiter_if
   import countdown_timer_arbiter_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH);
   logic [NREQ-1:0]  Req;
   logic [WIDTH-1:0] LoadVal0;
   logic [WIDTH-1:0] LoadVal1;
   logic [NREQ-1:0]  Gnt;
   logic             Busy;
   logic [WIDTH-1:0] Count;
   logic [NREQ-1:0]  Done;
`ifdef COUNTDOWN_TIMER_ARBITER_PAUSE_EN
   logic             Pause;
   modport master (output Req, LoadVal0, LoadVal1, Pause, input Gnt, Busy, Count, Done);
   modport slave  (input Req, LoadVal0, LoadVal1, Pause, output Gnt, Busy, Count, Done);
`else
   modport master (output Req, LoadVal0, LoadVal1, input Gnt, Busy, Count, Done);
   modport slave  (input Req, LoadVal0, LoadVal1, output Gnt, Busy, Count, Done);
`endif
endinterface

// File: rtl/countdown_timer_arbiter_down_counter.sv
// down_counter_sync: synchronous loadable down counter; load wins over decrement.
module down_counter_sync #(parameter int WIDTH = 4) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             Dec,
   output logic [WIDTH-1:0] Count,
   output logic             Zero
);
   always_ff @(posedge Clk) begin
      if (Rst)       Count <= '0;
      else if (Load) Count <= LoadVal;
      else if (Dec)  Count <= Count - 1'b1;
   end

   assign Zero = (Count == '0);
endmodule

// File: rtl/countdown_timer_arbiter.sv
// Round-robin sharing of one down-counting timer between two requesters.
// Optional freeze input enabled by COUNTDOWN_TIMER_ARBITER_PAUSE_EN.
module countdown_timer_arbiter
   import countdown_timer_arbiter_pkg::*;
   #(parameter int WIDTH = DEFAULT_WIDTH) (
   input  logic                     Clk,
   input  logic                     Rst,
   countdown_timer_arbiter_if.slave bus
);
   state_t           state, state_nxt;
   logic             ptr, ptr_nxt;
   logic             owner, owner_nxt;
   logic [NREQ-1:0]  gnt, gnt_nxt;
   logic             winner, load, dec, zero, paused;
   logic [WIDTH-1:0] cnt, load_val;

`ifdef COUNTDOWN_TIMER_ARBITER_PAUSE_EN
   assign paused = bus.Pause;
`else
   assign paused = 1'b0;
`endif

   // A lone requester wins outright; a tie goes to ptr.
   assign winner   = (bus.Req == 2'b01) ? 1'b0 : (bus.Req == 2'b10) ? 1'b1 : ptr;
   assign load_val = winner ? bus.LoadVal1 : bus.LoadVal0;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= ST_IDLE;
         ptr   <= 1'b0;
         owner <= 1'b0;
         gnt   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
         owner <= owner_nxt;
         gnt   <= gnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      owner_nxt = owner;
      gnt_nxt   = gnt;
      load      = 1'b0;
      dec       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|bus.Req) begin
               state_nxt = ST_COUNT;
               owner_nxt = winner;
               gnt_nxt   = onehot(winner);
               load      = 1'b1;
            end
         end
         ST_COUNT: begin
            // Abort outranks pause; release on abort or terminal count.
            if (!bus.Req[owner] || (!paused && zero)) begin
               state_nxt = ST_IDLE;
               gnt_nxt   = '0;
               ptr_nxt   = ~owner;
            end else if (!paused) begin
               dec = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   down_counter_sync #(.WIDTH(WIDTH)) u_cnt (
      .Clk     (Clk),
      .Rst     (Rst),
      .Load    (load),
      .LoadVal (load_val),
      .Dec     (dec),
      .Count   (cnt),
      .Zero    (zero)
   );

   assign bus.Gnt   = gnt;
   assign bus.Busy  = (state == ST_COUNT);
   assign bus.Count = cnt;
   assign bus.Done  = (state == ST_COUNT && zero && bus.Req[owner] && !paused)
                      ? onehot(owner) : '0;
endmodule

// File: tb/tb_countdown_timer_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a reference model.
module tb_countdown_timer_arbiter;
   logic Clk = 1'b0;
   logic Rst = 1'b1;
   int   total = 0;
   int   bad   = 0;
   logic pz    = 1'b0;

   countdown_timer_arbiter_if #(.WIDTH(4)) bus ();
   countdown_timer_arbiter #(.WIDTH(4)) dut (.Clk(Clk), .Rst(Rst), .bus(bus));

   always #5 Clk = ~Clk;

`ifdef COUNTDOWN_TIMER_ARBITER_PAUSE_EN
   assign bus.Pause = pz;
`endif

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Rst = 1'b1; bus.Req = 2'b00; tick(); Rst = 1'b0;
   endtask

   task automatic test_reset();
      bus.Req = 2'b00; bus.LoadVal0 = 4'd7; bus.LoadVal1 = 4'd7;
      Rst = 1'b1; tick(); tick();
      total++; if (bus.Gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", bus.Gnt); end
      total++; if (bus.Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.Busy); end
      total++; if (bus.Count !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus.Count); end
      total++; if (bus.Done !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", bus.Done); end
      Rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      bus.Req = 2'b01; bus.LoadVal0 = 4'd3;
      for (int k = 3; k >= 0; k--) begin
         tick();
         total++; if (bus.Gnt !== 2'b01 || bus.Count !== 4'(k)) begin bad++;
            $display("FAIL single_cnt got gnt=%b cnt=%0d exp gnt=01 cnt=%0d", bus.Gnt, bus.Count, k); end
         total++; if (bus.Done !== ((k == 0) ? 2'b01 : 2'b00)) begin bad++;
            $display("FAIL single_done k=%0d got=%b", k, bus.Done); end
      end
      tick();
      total++; if (bus.Gnt !== 2'b00 || bus.Busy !== 1'b0) begin bad++;
         $display("FAIL single_release got gnt=%b busy=%b exp 00/0", bus.Gnt, bus.Busy); end
      bus.Req = 2'b00; tick();
   endtask

   task automatic test_tie_rr();
      do_reset();
      bus.Req = 2'b11; bus.LoadVal0 = 4'd1; bus.LoadVal1 = 4'd2;
      tick();
      total++; if (bus.Gnt !== 2'b01 || bus.Count !== 4'd1) begin bad++;
         $display("FAIL tie_first got gnt=%b cnt=%0d exp 01/1", bus.Gnt, bus.Count); end
      tick(); tick();
      total++; if (bus.Gnt !== 2'b00) begin bad++; $display("FAIL tie_gap got=%b exp=00", bus.Gnt); end
      tick();
      total++; if (bus.Gnt !== 2'b10 || bus.Count !== 4'd2) begin bad++;
         $display("FAIL tie_second got gnt=%b cnt=%0d exp 10/2", bus.Gnt, bus.Count); end
      tick(); tick();
      total++; if (bus.Done !== 2'b10) begin bad++; $display("FAIL tie_done1 got=%b exp=10", bus.Done); end
      tick(); tick();
      total++; if (bus.Gnt !== 2'b01) begin bad++; $display("FAIL tie_third got=%b exp=01", bus.Gnt); end
      bus.Req = 2'b00; tick();
   endtask

   task automatic test_zero_load();
      do_reset();
      bus.Req = 2'b10; bus.LoadVal1 = 4'd0;
      tick();
      total++; if (bus.Gnt !== 2'b10 || bus.Done !== 2'b10) begin bad++;
         $display("FAIL zero_load got gnt=%b done=%b exp 10/10", bus.Gnt, bus.Done); end
      tick();
      total++; if (bus.Gnt !== 2'b00) begin bad++; $display("FAIL zero_release got=%b exp=00", bus.Gnt); end
      bus.Req = 2'b00; tick();
   endtask

   task automatic test_abort();
      do_reset();
      bus.Req = 2'b01; bus.LoadVal0 = 4'd9; bus.LoadVal1 = 4'd3;
      repeat (5) tick();
      total++; if (bus.Count !== 4'd5) begin bad++; $display("FAIL abort_pre got=%0d exp=5", bus.Count); end
      bus.Req = 2'b00; #1;
      total++; if (bus.Done !== 2'b00) begin bad++; $display("FAIL abort_done got=%b exp=00", bus.Done); end
      tick();
      total++; if (bus.Gnt !== 2'b00 || bus.Count !== 4'd5 || bus.Busy !== 1'b0) begin bad++;
         $display("FAIL abort_idle got gnt=%b cnt=%0d busy=%b exp 00/5/0", bus.Gnt, bus.Count, bus.Busy); end
      bus.Req = 2'b11; tick();
      total++; if (bus.Gnt !== 2'b10 || bus.Count !== 4'd3) begin bad++;
         $display("FAIL abort_ptr got gnt=%b cnt=%0d exp 10/3", bus.Gnt, bus.Count); end
      bus.Req = 2'b00; tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.Req = 2'b11; bus.LoadVal0 = 4'd4; bus.LoadVal1 = 4'd4;
      tick(); tick(); tick();
      total++; if (bus.Count !== 4'd2 || bus.Gnt !== 2'b01) begin bad++;
         $display("FAIL rstmid_pre got cnt=%0d gnt=%b exp 2/01", bus.Count, bus.Gnt); end
      Rst = 1'b1; tick(); Rst = 1'b0;
      total++; if (bus.Gnt !== 2'b00 || bus.Count !== 4'd0 || bus.Done !== 2'b00) begin bad++;
         $display("FAIL rstmid got gnt=%b cnt=%0d done=%b exp 00/0/00", bus.Gnt, bus.Count, bus.Done); end
      tick();
      total++; if (bus.Gnt !== 2'b01) begin bad++; $display("FAIL rstmid_ptr got=%b exp=01", bus.Gnt); end
      bus.Req = 2'b00; tick();
   endtask

`ifdef COUNTDOWN_TIMER_ARBITER_PAUSE_EN
   task automatic test_pause();
      do_reset();
      bus.Req = 2'b01; bus.LoadVal0 = 4'd2;
      tick(); tick();
      pz = 1'b1;
      repeat (3) begin
         tick();
         total++; if (bus.Count !== 4'd1) begin bad++; $display("FAIL pause_hold got=%0d exp=1", bus.Count); end
      end
      pz = 1'b0; tick();
      total++; if (bus.Done !== 2'b01) begin bad++; $display("FAIL pause_done got=%b exp=01", bus.Done); end
      pz = 1'b1; #1;
      total++; if (bus.Done !== 2'b00) begin bad++; $display("FAIL pause_supp got=%b exp=00", bus.Done); end
      tick();
      total++; if (bus.Gnt !== 2'b01 || bus.Done !== 2'b00) begin bad++;
         $display("FAIL pause_zero got gnt=%b done=%b exp 01/00", bus.Gnt, bus.Done); end
      pz = 1'b0; #1;
      total++; if (bus.Done !== 2'b01) begin bad++; $display("FAIL pause_fall got=%b exp=01", bus.Done); end
      bus.Req = 2'b00; tick(); tick();
   endtask
`endif

   // Reference model: an owner slot (-1 = free), remaining ticks, and the tie pointer.
   task automatic test_random();
      int own, rem, ptr;
      logic [1:0] eg, ed;
      do_reset();
      own = -1; rem = 0; ptr = 0;
      for (int c = 0; c < 600; c++) begin
         Rst = ($urandom_range(0, 99) == 0);
         if ($urandom_range(0, 3) == 0) bus.LoadVal0 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) bus.LoadVal1 = 4'($urandom_range(0, 15));
`ifdef COUNTDOWN_TIMER_ARBITER_PAUSE_EN
         pz = ($urandom_range(0, 4) == 0);
`endif
         if (own >= 0) begin
            bus.Req = 2'($urandom_range(0, 3));
            bus.Req[own] = ($urandom_range(0, 99) < 96);
         end else begin
            bus.Req = 2'($urandom_range(0, 3));
         end
         tick();
         if (Rst) begin
            own = -1; rem = 0; ptr = 0;
         end else if (own < 0) begin
            if (bus.Req != 2'b00) begin
               own = (bus.Req == 2'b01) ? 0 : (bus.Req == 2'b10) ? 1 : ptr;
               rem = (own == 1) ? int'(bus.LoadVal1) : int'(bus.LoadVal0);
            end
         end else if (!bus.Req[own] || (!pz && rem == 0)) begin
            ptr = 1 - own; own = -1;
         end else if (!pz) begin
            rem = rem - 1;
         end
         eg = (own < 0) ? 2'b00 : (own == 1) ? 2'b10 : 2'b01;
         ed = (own >= 0 && rem == 0 && bus.Req[own] && !pz) ? eg : 2'b00;
         total++; if (bus.Gnt !== eg || bus.Busy !== (own >= 0)) begin bad++;
            $display("FAIL rand_gnt c=%0d got gnt=%b busy=%b exp gnt=%b", c, bus.Gnt, bus.Busy, eg); end
         total++; if (bus.Count !== 4'(rem)) begin bad++;
            $display("FAIL rand_count c=%0d got=%0d exp=%0d", c, bus.Count, rem); end
         total++; if (bus.Done !== ed) begin bad++;
            $display("FAIL rand_done c=%0d got=%b exp=%b", c, bus.Done, ed); end
      end
      Rst = 1'b0; pz = 1'b0; bus.Req = 2'b00; tick(); tick();
   endtask

   initial begin
      bus.Req = 2'b00; bus.LoadVal0 = '0; bus.LoadVal1 = '0;
      test_reset();
      test_single();
      test_tie_rr();
      test_zero_load();
      test_abort();
      test_reset_mid();
`ifdef COUNTDOWN_TIMER_ARBITER_PAUSE_EN
      test_pause();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
